// File: rtl/cpu7_dbus_arb_pkg.sv
// cpu7_dbus_arb_pkg: shared widths, master ids and FSM state type for the data-bus arbiter
package cpu7_dbus_arb_pkg;
   localparam int GRLEN_DEF = 32;
   localparam int MAX_OUTST_DEF = 4;
   localparam logic ID_M0 = 1'b0;
   localparam logic ID_M1 = 1'b1;
   typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_e;
endpackage

// File: rtl/cpu7_dbus_tagq.sv
// cpu7_dbus_tagq: in-order 1-bit owner-id FIFO (clk/reset, push+din, pop, head/full/empty/count)
module cpu7_dbus_tagq #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       din,
   input  logic                       pop,
   output logic                       head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [AW-1:0] wp_q, rp_q;
   logic [CW-1:0] cnt_q;
   logic [DEPTH-1:0] mem_q;
   logic do_push, do_pop;
   assign full = cnt_q == CW'(DEPTH);
   assign empty = cnt_q == '0;
   assign count = cnt_q;
   assign head = mem_q[rp_q];
   assign do_pop = pop & !empty;
   // a push into a full queue is only legal when the head leaves in the same cycle
   assign do_push = push & (!full | do_pop);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wp_q <= '0;
         rp_q <= '0;
         cnt_q <= '0;
      end else begin
         wp_q <= do_push ? wp_q + AW'(1) : wp_q;
         rp_q <= do_pop ? rp_q + AW'(1) : rp_q;
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem_q[wp_q] <= din;
endmodule

// File: rtl/cpu7_dbus_arb.sv
// cpu7_dbus_arb: round-robin two-master arbiter for the data SRAM-like bus (m0=LSU, m1=cacheop/prefetch; muxed data_* to bus, in-order data_ok routing, arb_idle/arb_err status)
module cpu7_dbus_arb
   import cpu7_dbus_arb_pkg::*;
#(
   parameter int GRLEN = GRLEN_DEF,
   parameter int MAX_OUTST = MAX_OUTST_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             m0_req,
   input  logic [GRLEN-1:0] m0_addr,
   input  logic             m0_wr,
   input  logic [3:0]       m0_wstrb,
   input  logic [GRLEN-1:0] m0_wdata,
   output logic             m0_addr_ok,
   output logic             m0_data_ok,
   output logic [GRLEN-1:0] m0_rdata,
   input  logic             m1_req,
   input  logic [GRLEN-1:0] m1_addr,
   input  logic             m1_wr,
   input  logic [3:0]       m1_wstrb,
   input  logic [GRLEN-1:0] m1_wdata,
   output logic             m1_addr_ok,
   output logic             m1_data_ok,
   output logic [GRLEN-1:0] m1_rdata,
   output logic             data_req,
   output logic [GRLEN-1:0] data_addr,
   output logic             data_wr,
   output logic [3:0]       data_wstrb,
   output logic [GRLEN-1:0] data_wdata,
   input  logic             data_addr_ok,
   input  logic             data_data_ok,
   input  logic [GRLEN-1:0] data_rdata,
   output logic             arb_idle,
   output logic             arb_err
);
   localparam int CW = $clog2(MAX_OUTST) + 1;
   state_e state_q, state_d;
   logic owner_q, owner_d;
   logic prio_q;
   logic err_q;
   logic win, gnt, acc, pop;
   logic head, full, empty;
   logic [CW-1:0] cnt;
   // prio_q names the favoured master when both request; it flips away from each accepted winner
   assign win = (m0_req & m1_req) ? prio_q : m1_req;
   cpu7_dbus_tagq #(.DEPTH(MAX_OUTST)) u_tagq (
      .clk   (clk),
      .reset (reset),
      .push  (acc),
      .din   (gnt),
      .pop   (data_data_ok),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (cnt)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= S_IDLE;
         owner_q <= ID_M0;
         prio_q <= ID_M0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         prio_q <= acc ? ~gnt : prio_q;
         err_q <= err_q | (data_data_ok & empty);
      end
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      if (state_q == S_IDLE) begin
         state_d = (data_req & !data_addr_ok) ? S_LOCK : S_IDLE;
         owner_d = (data_req & !data_addr_ok) ? gnt : owner_q;
      end else begin
         state_d = data_addr_ok ? S_IDLE : S_LOCK;
      end
   end
   always_comb begin
      gnt = (state_q == S_LOCK) ? owner_q : win;
      // reset gates the request so the bus sees nothing while the arbiter is being cleared
      data_req = !reset & ((state_q == S_LOCK) | (!full & (m0_req | m1_req)));
      data_addr = !data_req ? '0 : gnt ? m1_addr : m0_addr;
      data_wr = data_req & (gnt ? m1_wr : m0_wr);
      data_wstrb = !data_req ? '0 : gnt ? m1_wstrb : m0_wstrb;
      data_wdata = !data_req ? '0 : gnt ? m1_wdata : m0_wdata;
      acc = data_req & data_addr_ok;
      m0_addr_ok = acc & (gnt == ID_M0);
      m1_addr_ok = acc & (gnt == ID_M1);
      pop = data_data_ok & !empty;
      m0_data_ok = pop & (head == ID_M0);
      m1_data_ok = pop & (head == ID_M1);
      m0_rdata = m0_data_ok ? data_rdata : '0;
      m1_rdata = m1_data_ok ? data_rdata : '0;
      arb_idle = (state_q == S_IDLE) & (cnt == '0);
      arb_err = err_q;
   end
endmodule
